serial_addsub: RTL and testbench

- Bit-serial adder/subtractor: one operand bit per clock, LSB first, through a full-adder slice built from two half adders plus an OR.
- Sits directly downstream of the half-adder primitive and consumes its sum/carry outputs.
- Gives the adder_subtractor project an area-minimal sequential datapath with a start/done handshake, carry-out and signed overflow.

---
 rtl/serial_addsub_if.sv | 17 +
 rtl/serial_addsub.sv | 90 +++++++++
 tb/tb_serial_addsub.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (output start, mode, a, b, input busy, done, result, cout, ovf);
  modport slave  (input start, mode, a, b, output busy, done, result, cout, ovf);
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one full-adder slice (two half adders + OR).
// Subtract is a + ~b + 1, so the carry is preloaded with mode.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opa, r_opb;
  logic [WIDTH-2:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout, r_ovf;

  logic             w_accept, w_last;
  logic             w_ha1_s, w_ha1_c, w_ha2_s, w_ha2_c, w_carry_nxt;
  logic [WIDTH-1:0] w_sum_nxt;

  assign w_accept = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Full-adder slice on the current LSBs.
  assign w_ha1_s     = r_opa[0] ^ r_opb[0];
  assign w_ha1_c     = r_opa[0] & r_opb[0];
  assign w_ha2_s     = w_ha1_s ^ r_carry;
  assign w_ha2_c     = w_ha1_s & r_carry;
  assign w_carry_nxt = w_ha1_c | w_ha2_c;
  assign w_sum_nxt   = {w_ha2_s, r_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = DONE;
      DONE:    w_state_nxt = w_accept ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == RUN);
    bus.done = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= bus.a;
      r_opb   <= bus.mode ? ~bus.b : bus.b;
      r_carry <= bus.mode;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_sum   <= w_sum_nxt[WIDTH-1:1];
      r_carry <= w_carry_nxt;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // On the MSB slice r_carry is the carry into the MSB.
        r_result <= w_sum_nxt;
        r_cout   <= w_carry_nxt;
        r_ovf    <= r_carry ^ w_carry_nxt;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed table, handshake corners, random vs model.
module tb_serial_addsub;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) bus ();
  serial_addsub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference computed from integer arithmetic and signed range limits.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                       output logic [W-1:0] res, output logic cout, output logic ovf);
    int ua, ub, sa, sb, us, ss;
    ua = int'(a);
    ub = int'(b);
    sa = ua >= 2**(W-1) ? ua - 2**W : ua;
    sb = ub >= 2**(W-1) ? ub - 2**W : ub;
    if (!mode) begin
      us = ua + ub;
      ss = sa + sb;
      cout = (us >= 2**W);
    end else begin
      us = ua - ub;
      ss = sa - sb;
      cout = (ua >= ub);
    end
    res = W'(us);
    ovf = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.mode  = mode;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.mode  = $urandom_range(0, 1);
  endtask

  // Called at the negedge after acceptance; returns at the negedge where done is seen.
  task automatic wait_done(input string name, output int busy_cyc);
    int guard;
    busy_cyc = 0;
    guard = 0;
    while (!bus.done && guard < 4 * W) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      guard++;
    end
    if (!bus.done) chk({name, "_timeout"}, 32'd0, 32'd1);
    else if (bus.busy) chk({name, "_busy_with_done"}, 32'd1, 32'd0);
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic mode, input logic [W-1:0] er, input logic ec,
                           input logic eo);
    int bc;
    start_op(a, b, mode);
    wait_done(name, bc);
    chk({name, "_busy_cycles"}, bc, W);
    chk({name, "_result"}, bus.result, er);
    chk({name, "_cout"}, bus.cout, ec);
    chk({name, "_ovf"}, bus.ovf, eo);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, bus.done, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    int bc;
    logic [W-1:0] mr;
    logic mc, mo;
    logic [W-1:0] ra, rb;
    logic rm;

    vecs[0] = '{a: 8'd100, b: 8'd27,  mode: 1'b0, res: 8'd127,  cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'd200, b: 8'd100, mode: 1'b0, res: 8'd44,   cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'd127, b: 8'd1,   mode: 1'b0, res: 8'h80,   cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'd5,   b: 8'd3,   mode: 1'b1, res: 8'd2,    cout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 8'd3,   b: 8'd5,   mode: 1'b1, res: 8'hFE,   cout: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 8'h80,  b: 8'd1,   mode: 1'b1, res: 8'h7F,   cout: 1'b1, ovf: 1'b1};

    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_result", bus.result, 8'd0);
    chk("reset_cout", bus.cout, 1'b0);
    chk("reset_ovf", bus.ovf, 1'b0);
    rst = 1'b0;

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mode,
                vecs[i].res, vecs[i].cout, vecs[i].ovf);

    // Abort mid-operation: outputs clear without waiting for a clock edge.
    start_op(8'd200, 8'd100, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_result", bus.result, 8'd0);
    chk("abort_cout", bus.cout, 1'b0);
    chk("abort_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bc = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (bus.done || bus.busy) bc++;
    end
    chk("abort_no_done", bc, 0);
    run_check("after_abort", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);

    // start pulsed during RUN must not disturb the operation in flight.
    start_op(8'd10, 8'd20, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd1;
    bus.b = 8'd1;
    bus.mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore", bc);
    chk("ignore_result", bus.result, 8'd30);
    chk("ignore_cout", bus.cout, 1'b0);

    // Back-to-back: start held through DONE, no IDLE gap, old result held.
    start_op(8'd5, 8'd6, 1'b0);
    wait_done("b2b_first", bc);
    chk("b2b_first_result", bus.result, 8'd11);
    bus.start = 1'b1;
    bus.a = 8'd1;
    bus.b = 8'd1;
    bus.mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_no_gap_busy", bus.busy, 1'b1);
    chk("b2b_result_held", bus.result, 8'd11);
    wait_done("b2b_second", bc);
    chk("b2b_second_busy_cycles", bc, W);
    chk("b2b_second_result", bus.result, 8'd2);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 8'hFF; rb = 8'hFF; rm = 1'b0; end
      if (i == 1) begin ra = 8'h00; rb = 8'h00; rm = 1'b1; end
      model(ra, rb, rm, mr, mc, mo);
      run_check($sformatf("rand%0d", i), ra, rb, rm, mr, mc, mo);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
